// File: rtl/mem_store_pkg.sv
// mem_store_pkg: shared sizing helpers and the response-stage record for mem_store.
package mem_store_pkg;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   // A single requester still needs a one-bit tag so rsp_ch never collapses to zero width.
   function automatic int ch_width(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction
   typedef struct packed {
      logic valid;
      logic write;
      logic err;
   } rsp_stage_t;
endpackage

// File: rtl/mem_store_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over NUM_CH requesters, pointer moves past each winner.
module rr_arbiter
   import mem_store_pkg::*;
#(
   parameter int NUM_CH = 2,
   localparam int CH_W = ch_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_ch
);
   logic [CH_W-1:0] ptr;
   logic            hit;
   // Wrapped candidates below the pointer are found first, then overridden by any at or above it.
   always_comb begin
      grant_ch = '0;
      hit = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (req[i] && i < int'(ptr)) begin
            grant_ch = CH_W'(i);
            hit = 1'b1;
         end
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (req[i] && i >= int'(ptr)) begin
            grant_ch = CH_W'(i);
            hit = 1'b1;
         end
      grant = (hit && !rst) ? NUM_CH'(1) << grant_ch : '0;
   end
   always_ff @(posedge clk)
      if (rst) ptr <= '0;
      else if (hit) ptr <= (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + 1'b1;
endmodule

// File: rtl/mem_store.sv
// mem_store: round-robin shared scratchpad with fixed-latency tagged completions for every access.
module mem_store
   import mem_store_pkg::*;
#(
   parameter int DATA_W  = 256,
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = 5,
   parameter int NUM_CH  = 2,
   parameter int LATENCY = 3,
   localparam int CH_W   = ch_width(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        req_valid,
   output logic [NUM_CH-1:0]        req_ready,
   input  logic [NUM_CH-1:0]        req_write,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*DATA_W-1:0] req_wdata,
   output logic                     rsp_valid,
   output logic [CH_W-1:0]          rsp_ch,
   output logic                     rsp_write,
   output logic                     rsp_err,
   output logic [DATA_W-1:0]        rsp_data
);
   localparam int IDX_W = clog2(DEPTH);
   logic [NUM_CH-1:0] grant;
   logic [CH_W-1:0]   grant_ch;
   logic              accept, sel_write, in_range;
   logic [ADDR_W-1:0] sel_addr;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] sel_wdata, rd_data;
   logic [DATA_W-1:0] mem [DEPTH];
   rsp_stage_t        tag_q [LATENCY];
   logic [CH_W-1:0]   ch_q [LATENCY];
   logic [DATA_W-1:0] data_q [LATENCY];
   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk(clk),
      .rst(rst),
      .req(req_valid),
      .grant(grant),
      .grant_ch(grant_ch)
   );
   assign req_ready = grant;
   assign accept = |grant;
   always_comb begin
      sel_write = 1'b0;
      sel_addr = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (grant[i]) begin
            sel_write = req_write[i];
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
   end
   assign in_range = int'(sel_addr) < DEPTH;
   assign idx = sel_addr[IDX_W-1:0];
   assign rd_data = (accept && in_range && !sel_write) ? mem[idx] : '0;
   always_ff @(posedge clk)
      if (accept && sel_write && in_range) mem[idx] <= sel_wdata;
   // Idle stages carry all-zero records so rsp_* read 0 between completions.
   always_ff @(posedge clk)
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            tag_q[i] <= '0;
            ch_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= accept ? '{valid: 1'b1, write: sel_write, err: !in_range} : '0;
         ch_q[0] <= accept ? grant_ch : '0;
         data_q[0] <= rd_data;
         for (int i = 1; i < LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
            ch_q[i] <= ch_q[i-1];
            data_q[i] <= data_q[i-1];
         end
      end
   assign rsp_valid = tag_q[LATENCY-1].valid;
   assign rsp_write = tag_q[LATENCY-1].write;
   assign rsp_err = tag_q[LATENCY-1].err;
   assign rsp_ch = ch_q[LATENCY-1];
   assign rsp_data = data_q[LATENCY-1];
endmodule

// File: tb/tb_mem_store.sv
// tb_mem_store: scoreboard bench for the default build and a 32x5, 3-channel, latency-1 build.
module tb_mem_store;
   typedef struct {
      int           due;
      int           ch;
      logic         w;
      logic         e;
      logic [255:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   pa = 0;
   int   pb = 0;
   exp_t qa[$], qb[$];
   exp_t xa, xb;
   logic [255:0] ma [8];
   logic [31:0]  mb [5];

   logic [1:0]   a_valid = '0, a_write = '0, a_ready;
   logic [9:0]   a_addr = '0;
   logic [511:0] a_wdata = '0;
   logic         a_rv, a_rw, a_re;
   logic [0:0]   a_rch;
   logic [255:0] a_rd;

   logic [2:0]   b_valid = '0, b_write = '0, b_ready;
   logic [14:0]  b_addr = '0;
   logic [95:0]  b_wdata = '0;
   logic         b_rv, b_rw, b_re;
   logic [1:0]   b_rch;
   logic [31:0]  b_rd;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mem_store dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
      .req_addr(a_addr), .req_wdata(a_wdata),
      .rsp_valid(a_rv), .rsp_ch(a_rch), .rsp_write(a_rw), .rsp_err(a_re), .rsp_data(a_rd)
   );

   mem_store #(.DATA_W(32), .DEPTH(5), .ADDR_W(5), .NUM_CH(3), .LATENCY(1)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
      .req_addr(b_addr), .req_wdata(b_wdata),
      .rsp_valid(b_rv), .rsp_ch(b_rch), .rsp_write(b_rw), .rsp_err(b_re), .rsp_data(b_rd)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input int unsigned v, input int p, input int n);
      for (int k = 0; k < n; k++)
         if (v[(p + k) % n]) return (p + k) % n;
      return -1;
   endfunction

   task automatic step_a(input logic [1:0] v, input logic [1:0] w, input logic [9:0] ad, input logic [511:0] wd);
      int g;
      logic [4:0] a;
      exp_t x;
      @(negedge clk);
      a_valid = v; a_write = w; a_addr = ad; a_wdata = wd;
      #1;
      g = rst ? -1 : pick(32'(v), pa, 2);
      chk("a_ready", 256'(a_ready), (g < 0) ? 256'd0 : 256'(1) << g);
      if (g >= 0) begin
         a = ad[g*5 +: 5];
         x.due = cyc + 3; x.ch = g; x.w = w[g]; x.e = (a >= 8);
         x.d = (x.w || x.e) ? 256'd0 : ma[a[2:0]];
         if (x.w && !x.e) ma[a[2:0]] = wd[g*256 +: 256];
         qa.push_back(x);
         pa = (g + 1) % 2;
      end
   endtask

   task automatic step_b(input logic [2:0] v, input logic [2:0] w, input logic [14:0] ad, input logic [95:0] wd);
      int g;
      logic [4:0] a;
      exp_t x;
      @(negedge clk);
      b_valid = v; b_write = w; b_addr = ad; b_wdata = wd;
      #1;
      g = rst ? -1 : pick(32'(v), pb, 3);
      chk("b_ready", 256'(b_ready), (g < 0) ? 256'd0 : 256'(1) << g);
      if (g >= 0) begin
         a = ad[g*5 +: 5];
         x.due = cyc + 1; x.ch = g; x.w = w[g]; x.e = (a >= 5);
         x.d = (x.w || x.e) ? 256'd0 : 256'(mb[a[2:0]]);
         if (x.w && !x.e) mb[a[2:0]] = wd[g*32 +: 32];
         qb.push_back(x);
         pb = (g + 1) % 3;
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_a_rv"}, 256'(a_rv), 256'd0);
      chk({tag, "_a_rch"}, 256'(a_rch), 256'd0);
      chk({tag, "_a_rw"}, 256'(a_rw), 256'd0);
      chk({tag, "_a_re"}, 256'(a_re), 256'd0);
      chk({tag, "_a_rd"}, a_rd, 256'd0);
      chk({tag, "_b_rv"}, 256'(b_rv), 256'd0);
      chk({tag, "_b_rch"}, 256'(b_rch), 256'd0);
      chk({tag, "_b_rd"}, 256'(b_rd), 256'd0);
   endtask

   always @(negedge clk) begin
      if (a_rv) begin
         if (qa.size() == 0) chk("a_unexpected_rsp", 256'(a_rv), 256'd0);
         else begin
            xa = qa.pop_front();
            chk("a_rsp_cycle", 256'(cyc), 256'(xa.due));
            chk("a_rsp_ch", 256'(a_rch), 256'(xa.ch));
            chk("a_rsp_write", 256'(a_rw), 256'(xa.w));
            chk("a_rsp_err", 256'(a_re), 256'(xa.e));
            chk("a_rsp_data", a_rd, xa.d);
         end
      end else if (qa.size() != 0 && qa[0].due <= cyc) begin
         void'(qa.pop_front());
         chk("a_rsp_missing", 256'(a_rv), 256'd1);
      end
   end

   always @(negedge clk) begin
      if (b_rv) begin
         if (qb.size() == 0) chk("b_unexpected_rsp", 256'(b_rv), 256'd0);
         else begin
            xb = qb.pop_front();
            chk("b_rsp_cycle", 256'(cyc), 256'(xb.due));
            chk("b_rsp_ch", 256'(b_rch), 256'(xb.ch));
            chk("b_rsp_write", 256'(b_rw), 256'(xb.w));
            chk("b_rsp_err", 256'(b_re), 256'(xb.e));
            chk("b_rsp_data", 256'(b_rd), xb.d);
         end
      end else if (qb.size() != 0 && qb[0].due <= cyc) begin
         void'(qb.pop_front());
         chk("b_rsp_missing", 256'(b_rv), 256'd1);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [14:0] bad_vec;
      logic [95:0] bwd;
      // Requests held during reset must never be granted.
      repeat (3) begin
         step_a(2'b11, 2'b00, '0, '0);
         step_b(3'b111, 3'b000, '0, '0);
      end
      chk_quiet("reset");
      @(negedge clk);
      a_valid = '0; b_valid = '0; rst = 1'b0;
      repeat (10) step_a(2'b00, 2'b00, '0, '0);
      chk_quiet("idle");

      for (int i = 0; i < 8; i++) step_a(2'b01, 2'b01, {5'd0, 5'(i)}, {256'd0, {8{$urandom}}});
      step_a(2'b01, 2'b01, {5'd0, 5'd3}, {256'd0, 256'hA5});
      step_a(2'b10, 2'b00, {5'd3, 5'd0}, '0);
      repeat (6) step_a(2'b11, 2'b00, {5'd1, 5'd0}, '0);
      step_a(2'b01, 2'b00, {5'd0, 5'd9}, '0);
      step_a(2'b10, 2'b10, {5'd31, 5'd0}, {{8{$urandom}}, 256'd0});
      step_a(2'b01, 2'b01, {5'd0, 5'd8}, {256'd0, {8{$urandom}}});
      for (int i = 0; i < 8; i++) step_a(2'b10, 2'b00, {5'(i), 5'd0}, '0);
      repeat (4) step_a(2'b00, 2'b00, '0, '0);

      // Mid-flight reset: the first read completes before the reset edge, the last two are dropped.
      step_a(2'b10, 2'b10, {5'd5, 5'd0}, {256'hDEAD_BEEF, 256'd0});
      for (int i = 5; i < 8; i++) step_a(2'b01, 2'b00, {5'd0, 5'(i)}, '0);
      @(negedge clk);
      rst = 1'b1; a_valid = '0; b_valid = '0;
      #1;
      qa.delete(); qb.delete(); pa = 0; pb = 0;
      @(negedge clk);
      #1;
      chk_quiet("midreset");
      rst = 1'b0;
      repeat (5) step_a(2'b00, 2'b00, '0, '0);
      step_a(2'b11, 2'b00, {5'd5, 5'd5}, '0);
      step_a(2'b11, 2'b00, {5'd5, 5'd5}, '0);
      repeat (4) step_a(2'b00, 2'b00, '0, '0);

      for (int i = 0; i < 5; i++) begin
         bad_vec = '0; bwd = '0;
         bad_vec[(i % 3)*5 +: 5] = 5'(i);
         bwd[(i % 3)*32 +: 32] = $urandom;
         step_b(3'(1 << (i % 3)), 3'(1 << (i % 3)), bad_vec, bwd);
      end
      for (int i = 0; i < 5; i++) step_b(3'b100, 3'b000, {5'(i), 10'd0}, '0);
      repeat (6) step_b(3'b111, 3'b000, {5'd2, 5'd1, 5'd0}, '0);
      step_b(3'b010, 3'b000, {5'd0, 5'd5, 5'd0}, '0);
      step_b(3'b001, 3'b001, {10'd0, 5'd7}, {64'd0, 32'h1234_5678});
      step_b(3'b001, 3'b000, {10'd0, 5'd4}, '0);
      repeat (3) step_b(3'b000, 3'b000, '0, '0);
      repeat (4) step_a(2'b00, 2'b00, '0, '0);

      chk("a_queue_drained", 256'(qa.size()), 256'd0);
      chk("b_queue_drained", 256'(qb.size()), 256'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
